pwm_duty_gen: RTL and testbench

- Downstream consumer of the Nios II duty PIO (32-bit out_port) in the PWM experiment.
- Converts the software-written duty word into a glitch-free servo/ESC PWM waveform.
- Has a prescaled period counter, a shadow duty register updated only at period boundaries, min/max clamping, and a clean stop at the end of a period.

---
 rtl/pwm_duty_gen_if.sv | 24 ++
 rtl/pwm_duty_gen.sv | 151 +++++++++++++++
 tb/tb_pwm_duty_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_gen_if.sv
// Control/status bundle between the Nios II duty PIO side (master) and
// the PWM generator (slave).
interface pwm_duty_gen_if #(
    parameter int CNT_W = 20
);
    logic             enable;
    logic [31:0]      duty_in;
    logic             duty_wr;
    logic             pwm_out;
    logic             period_start;
    logic [CNT_W-1:0] duty_active;
    logic             running;
    logic             failsafe;

    modport master (
        output enable, duty_in, duty_wr,
        input  pwm_out, period_start, duty_active, running, failsafe
    );

    modport slave (
        input  enable, duty_in, duty_wr,
        output pwm_out, period_start, duty_active, running, failsafe
    );
endinterface

// File: rtl/pwm_duty_gen.sv
// Servo/ESC PWM generator: prescaled period counter, duty reload only at period
// boundaries with min/max clamping, clean stop at period end. Macro PWM_FAILSAFE_EN adds failsafe.
module pwm_duty_gen #(
    parameter int CNT_W      = 20,
    parameter int PRESCALE   = 50,
    parameter int PERIOD     = 20000,
    parameter int DUTY_MIN   = 1000,
    parameter int DUTY_MAX   = 2000,
    parameter int FS_PERIODS = 10,
    parameter int FS_DUTY    = 1000
) (
    input  logic          clk,
    input  logic          reset_n,
    pwm_duty_gen_if.slave bus
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {OFF, RUN, STOPPING} state_t;

    state_t           state;
    logic [PS_W-1:0]  prescaler;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_q;
    logic             pwm_q;
    logic             start_q;
    logic             running_q;
    logic             failsafe_q;

    logic [CNT_W-1:0] clamped;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt_adv;
    logic             tick;
    logic             boundary;
    logic             start_period;
    logic             going_off;

    // Clamp is evaluated on the full 32-bit word so upper bits push it to DUTY_MAX.
    always_comb begin
        if (bus.duty_in == 32'd0)
            clamped = '0;
        else if (bus.duty_in < 32'(DUTY_MIN))
            clamped = CNT_W'(DUTY_MIN);
        else if (bus.duty_in > 32'(DUTY_MAX))
            clamped = CNT_W'(DUTY_MAX);
        else
            clamped = bus.duty_in[CNT_W-1:0];
    end

    assign tick      = (prescaler == PS_W'(PRESCALE - 1));
    assign boundary  = tick && (cnt == CNT_W'(PERIOD - 1));
    assign cnt_adv   = tick ? cnt + CNT_W'(1) : cnt;
    assign going_off = (state == STOPPING) && boundary && !bus.enable;

    always_comb begin
        start_period = 1'b0;
        if (state == OFF)
            start_period = bus.enable;
        else if (state == RUN || state == STOPPING)
            start_period = boundary && !going_off;
    end

    // pwm_q is computed from the values cnt/duty_q take on this same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= OFF;
            prescaler <= '0;
            cnt       <= '0;
            duty_q    <= '0;
            pwm_q     <= 1'b0;
            start_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            start_q <= start_period;
            if (start_period)
                duty_q <= load_val;
            case (state)
                OFF: begin
                    prescaler <= '0;
                    cnt       <= '0;
                    pwm_q     <= bus.enable && (load_val != '0);
                    running_q <= bus.enable;
                    if (bus.enable)
                        state <= RUN;
                end
                RUN, STOPPING: begin
                    prescaler <= tick ? '0 : prescaler + PS_W'(1);
                    cnt       <= boundary ? '0 : cnt_adv;
                    if (going_off) begin
                        state     <= OFF;
                        pwm_q     <= 1'b0;
                        running_q <= 1'b0;
                    end else begin
                        state     <= bus.enable ? RUN : STOPPING;
                        running_q <= 1'b1;
                        pwm_q     <= boundary ? (load_val != '0) : (cnt_adv < duty_q);
                    end
                end
                default: begin
                    state     <= OFF;
                    prescaler <= '0;
                    cnt       <= '0;
                    pwm_q     <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PWM_FAILSAFE_EN
    logic [7:0] fs_cnt;
    logic [7:0] fs_next;
    logic       fs_clear;

    assign fs_clear = ((state == OFF) && !bus.enable) || bus.duty_wr;

    always_comb begin
        fs_next = fs_cnt;
        if (fs_clear)
            fs_next = '0;
        else if (start_period && fs_cnt != 8'hFF)
            fs_next = fs_cnt + 8'd1;
    end

    // A write on a boundary cycle wins: it clears failsafe and normal duty loads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fs_cnt     <= '0;
            failsafe_q <= 1'b0;
        end else begin
            fs_cnt <= fs_next;
            if (fs_clear)
                failsafe_q <= 1'b0;
            else if (fs_next >= 8'(FS_PERIODS))
                failsafe_q <= 1'b1;
        end
    end

    assign load_val = (failsafe_q && !bus.duty_wr) ? CNT_W'(FS_DUTY) : clamped;
`else
    logic unused_fs;
    assign unused_fs  = &{1'b0, bus.duty_wr, FS_PERIODS[0], FS_DUTY[0]};
    assign failsafe_q = 1'b0;
    assign load_val   = clamped;
`endif

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = start_q;
    assign bus.duty_active  = duty_q;
    assign bus.running      = running_q;
    assign bus.failsafe     = failsafe_q;
endmodule

// File: tb/tb_pwm_duty_gen.sv
// Directed self-checking bench for pwm_duty_gen with PRESCALE=2, PERIOD=20 (40 clk
// periods), DUTY_MIN=2, DUTY_MAX=15; failsafe checks follow PWM_FAILSAFE_EN.
module tb_pwm_duty_gen;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;
    int   high;
    int   len;
    logic any_activity;

`ifdef PWM_FAILSAFE_EN
    localparam logic FS_ON    = 1'b1;
    localparam int   FS_ACT   = 4;
    localparam int   FS_HIGH  = 8;
`else
    localparam logic FS_ON    = 1'b0;
    localparam int   FS_ACT   = 5;
    localparam int   FS_HIGH  = 10;
`endif

    pwm_duty_gen_if #(.CNT_W(20)) bus ();

    pwm_duty_gen #(
        .CNT_W(20), .PRESCALE(2), .PERIOD(20), .DUTY_MIN(2), .DUTY_MAX(15),
        .FS_PERIODS(3), .FS_DUTY(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [31:0] duty, input logic wr);
        bus.enable  = en;
        bus.duty_in = duty;
        bus.duty_wr = wr;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
            $error("[TB] check %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Starts on a period_start sample; ends on the next period_start, on running
    // falling, or after 200 samples. Optional write, enable drop and re-enable by sample index.
    task automatic runPeriod(input int chg_at, input logic [31:0] chg_val, input int drop_at,
                             input int back_at, output int hi, output int n);
        hi = 0;
        n  = 0;
        do begin
            if (n == chg_at)
                applyStimulus(bus.enable, chg_val, 1'b1);
            else
                bus.duty_wr = 1'b0;
            if (n == drop_at) bus.enable = 1'b0;
            if (n == back_at) bus.enable = 1'b1;
            if (bus.pwm_out) hi++;
            n++;
            waitCycles(1);
        end while (!bus.period_start && bus.running && n < 200);
        bus.duty_wr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0);
        waitCycles(3);
        checkOutput("rst_pwm", bus.pwm_out, 0);
        checkOutput("rst_running", bus.running, 0);
        checkOutput("rst_pstart", bus.period_start, 0);
        checkOutput("rst_duty", bus.duty_active, 0);
        checkOutput("rst_failsafe", bus.failsafe, 0);

        reset_n = 1'b1;
        waitCycles(2);
        checkOutput("idle_running", bus.running, 0);

        $display("[TB] start with duty 5");
        applyStimulus(1'b1, 32'd5, 1'b1);
        waitCycles(1);
        bus.duty_wr = 1'b0;
        checkOutput("start_pstart", bus.period_start, 1);
        checkOutput("start_running", bus.running, 1);
        checkOutput("start_duty", bus.duty_active, 5);
        checkOutput("start_pwm", bus.pwm_out, 1);
        runPeriod(20, 32'd5, -1, -1, high, len);
        checkOutput("p1_high", high, 10);
        checkOutput("p1_len", len, 40);

        $display("[TB] mid-period change 5 -> 8");
        runPeriod(6, 32'd8, -1, -1, high, len);
        checkOutput("keep_high", high, 10);
        checkOutput("keep_len", len, 40);
        checkOutput("chg_duty", bus.duty_active, 8);
        runPeriod(20, 32'd1, -1, -1, high, len);
        checkOutput("chg_high", high, 16);

        $display("[TB] clamp cases");
        checkOutput("min_duty", bus.duty_active, 2);
        runPeriod(20, 32'h0001_0005, -1, -1, high, len);
        checkOutput("min_high", high, 4);
        checkOutput("max_duty", bus.duty_active, 15);
        runPeriod(20, 32'd0, -1, -1, high, len);
        checkOutput("max_high", high, 30);
        checkOutput("zero_duty", bus.duty_active, 0);
        runPeriod(20, 32'd5, -1, -1, high, len);
        checkOutput("zero_high", high, 0);
        checkOutput("zero_len", len, 40);
        checkOutput("zero_pstart", bus.period_start, 1);

        $display("[TB] stop 3 clk into period");
        runPeriod(-1, 32'd5, 3, -1, high, len);
        checkOutput("stop_high", high, 10);
        checkOutput("stop_len", len, 40);
        checkOutput("stop_running", bus.running, 0);
        checkOutput("stop_pstart", bus.period_start, 0);
        checkOutput("stop_duty", bus.duty_active, 5);
        any_activity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            any_activity = any_activity | bus.pwm_out | bus.period_start | bus.running;
            waitCycles(1);
        end
        checkOutput("off_quiet", any_activity, 0);

        $display("[TB] re-enable during stopping");
        applyStimulus(1'b1, 32'd5, 1'b1);
        waitCycles(1);
        bus.duty_wr = 1'b0;
        checkOutput("restart_pstart", bus.period_start, 1);
        runPeriod(20, 32'd5, 3, 8, high, len);
        checkOutput("reen_high", high, 10);
        checkOutput("reen_len", len, 40);
        checkOutput("reen_pstart", bus.period_start, 1);

        $display("[TB] reset mid-pulse");
        waitCycles(4);
        checkOutput("pre_rst_pwm", bus.pwm_out, 1);
        reset_n = 1'b0;
        #2;
        checkOutput("arst_pwm", bus.pwm_out, 0);
        checkOutput("arst_running", bus.running, 0);
        checkOutput("arst_duty", bus.duty_active, 0);
        waitCycles(2);
        reset_n = 1'b1;
        waitCycles(1);
        checkOutput("resume_pstart", bus.period_start, 1);
        checkOutput("resume_duty", bus.duty_active, 5);

        $display("[TB] periods without duty writes");
        runPeriod(-1, 32'd5, -1, -1, high, len);
        checkOutput("resume_high", high, 10);
        runPeriod(-1, 32'd5, -1, -1, high, len);
        checkOutput("nw2_high", high, 10);
        checkOutput("fs_set", bus.failsafe, FS_ON);
        runPeriod(-1, 32'd5, -1, -1, high, len);
        checkOutput("nw3_high", high, 10);
        checkOutput("fs_duty", bus.duty_active, FS_ACT);
        runPeriod(10, 32'd5, -1, -1, high, len);
        checkOutput("fs_high", high, FS_HIGH);
        checkOutput("fs_clear", bus.failsafe, 0);
        checkOutput("fs_back_duty", bus.duty_active, 5);
        runPeriod(20, 32'd5, -1, -1, high, len);
        checkOutput("fs_back_high", high, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
